traffic_injector: RTL

Parametrised synthetic-traffic source for the NoC local port: the next-generation per-PE injector. It builds packets `{PacketID, SrcID, DstID, Payload}` and offers them to the router's local input FIFO over a request/grant handshake, honouring the `DnStrFull` backpressure flag. Compared with the fixed-ID, fixed-delay injector it adds run-time enable, programmable inter-packet gap, fixed/uniform-random/bit-complement destination modes, an LFSR payload and a packet budget with a `Done` flag.

---
 rtl/traffic_injector_if.sv | 23 ++
 rtl/traffic_injector.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/traffic_injector_if.sv
// rtl/traffic_injector_if.sv - local-port request/grant handshake between injector and router input FIFO
interface traffic_injector_if #(
  parameter int PACKETWIDTH = 32
);
  logic                   ReqDnStr;
  logic                   GntDnStr;
  logic                   DnStrFull;
  logic [PACKETWIDTH-1:0] PacketOut;

  modport master (
    output ReqDnStr,
    output PacketOut,
    input  GntDnStr,
    input  DnStrFull
  );

  modport slave (
    input  ReqDnStr,
    input  PacketOut,
    output GntDnStr,
    output DnStrFull
  );
endinterface

// File: rtl/traffic_injector.sv
// rtl/traffic_injector.sv - synthetic NoC packet source with gap, dest modes, LFSR payload and packet budget
// TRAFFIC_INJECTOR_STATS_EN adds SentCount/StallCycles counter outputs.
module traffic_injector #(
  parameter int              ID_W        = 6,
  parameter logic [ID_W-1:0] ROUTER_ID   = 6'b000_010,
  parameter int              PID_W       = 10,
  parameter int              PAY_W       = 10,
  parameter int              PACKETWIDTH = 32,
  parameter int              GAP_W       = 16,
  parameter int              MAX_PKTS    = 1023,
  parameter logic [15:0]     LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Enable,
  input  logic [1:0]          Mode,
  input  logic [ID_W-1:0]     CfgDest,
  input  logic [GAP_W-1:0]    CfgGap,
`ifdef TRAFFIC_INJECTOR_STATS_EN
  output logic [PID_W:0]      SentCount,
  output logic [15:0]         StallCycles,
`endif
  output logic                Done,
  traffic_injector_if.master  bus
);

  localparam int              SENT_W    = PID_W + 1;
  localparam logic [SENT_W-1:0] MAX_CNT = SENT_W'(MAX_PKTS);
  localparam bit              BUDGET_EN = (MAX_PKTS != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_WAIT_GNT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [GAP_W-1:0]       count_q, count_d;
  logic [PID_W-1:0]       pid_q, pid_d;
  logic [SENT_W-1:0]      sent_q, sent_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   req_q, req_d;
  logic [PACKETWIDTH-1:0] data_q, data_d;

  logic                   gap_expired;
  logic [ID_W-1:0]        rnd_dst;
  logic [ID_W-1:0]        dst_sel;
  logic [PACKETWIDTH-1:0] next_pkt;

  // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  assign gap_expired = !(count_q < CfgGap);
  assign rnd_dst     = lfsr_q[ID_W+7:8];

  always_comb begin
    dst_sel = CfgDest;
    unique case (Mode)
      2'b01:   dst_sel = (rnd_dst == ROUTER_ID) ? (rnd_dst ^ ID_W'(1)) : rnd_dst;
      2'b10:   dst_sel = ~ROUTER_ID;
      default: dst_sel = CfgDest;
    endcase
  end

  assign next_pkt = {pid_q, ROUTER_ID, dst_sel, lfsr_q[PAY_W-1:0]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pid_d   = pid_q;
    sent_d  = sent_q;
    req_d   = req_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (Enable) state_d = S_GAP;
      end
      S_GAP: begin
        if (!Enable) begin
          state_d = S_IDLE;
        end else if (!gap_expired) begin
          count_d = count_q + 1'b1;
        end else if (!bus.DnStrFull) begin
          data_d  = next_pkt;
          req_d   = 1'b1;
          count_d = '0;
          state_d = S_WAIT_GNT;
        end
      end
      // Request is held regardless of Enable or DnStrFull until granted
      S_WAIT_GNT: begin
        if (bus.GntDnStr) begin
          req_d  = 1'b0;
          pid_d  = pid_q + 1'b1;
          sent_d = sent_q + 1'b1;
          if (BUDGET_EN && (sent_d == MAX_CNT)) state_d = S_DONE;
          else if (Enable)                       state_d = S_GAP;
          else                                   state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (!Enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pid_q   <= '0;
      sent_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pid_q   <= pid_d;
      sent_q  <= sent_d;
      lfsr_q  <= lfsr_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign bus.ReqDnStr  = req_q;
  assign bus.PacketOut = data_q;
  assign Done          = (state_q == S_DONE);

`ifdef TRAFFIC_INJECTOR_STATS_EN
  logic        stall_evt;
  logic [15:0] stall_q;

  assign stall_evt = (state_q == S_GAP) && Enable && gap_expired && bus.DnStrFull;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stall_evt && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign SentCount   = sent_q;
  assign StallCycles = stall_q;
`endif

endmodule
